// File: rtl/network_tx_gmii_serializer.sv
// GMII transmit serializer: buffers 134-bit PCB words, adds preamble/SFD and enforces the inter-frame gap.
// Defining NET_TX_STAT_EN adds frame and underrun statistics counters.
module network_tx_gmii_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int IFG_CYCLES = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [133:0] iv_pkt_data,
    input  logic         i_pkt_data_wr,
    output logic         o_pkt_rd_req,
    output logic         o_pkt_rx_valid,
    output logic         o_pkt_last_cycle_rx,
    output logic [7:0]   ov_gmii_txd,
    output logic         o_gmii_tx_en,
    output logic         o_gmii_tx_er,
    output logic         o_fifo_overflow
`ifdef NET_TX_STAT_EN
    ,
    output logic [15:0]  ov_tx_pkt_cnt,
    output logic [15:0]  ov_tx_underrun_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    localparam logic [2:0] IDLE_S = 3'd0;
    localparam logic [2:0] PRE_S  = 3'd1;
    localparam logic [2:0] DATA_S = 3'd2;
    localparam logic [2:0] DROP_S = 3'd3;
    localparam logic [2:0] IFG_S  = 3'd4;

    logic [133:0]  mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_n_s;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    logic [133:0]  head_s;
    logic [1:0]    head_flag_s;
    logic [3:0]    last_idx_s;
    logic [7:0]    bytes_s [16];

    logic [2:0]    state_r;
    logic [2:0]    state_n_s;
    logic [15:0]   cnt_r;
    logic [15:0]   cnt_n_s;
    logic [7:0]    txd_n_s;
    logic          tx_en_n_s;
    logic          tx_er_n_s;

    logic          rd_req_r;
    logic          rx_valid_r;
    logic          last_rx_r;
    logic          overflow_r;
    logic [7:0]    txd_r;
    logic          tx_en_r;
    logic          tx_er_r;

    // Occupancy comes from the count alone, so full and empty never alias on equal pointers.
    assign full_s      = (count_r == CW'(FIFO_DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign push_s      = i_pkt_data_wr & ~full_s;
    assign head_s      = mem_r[rd_ptr_r];
    assign head_flag_s = head_s[133:132];
    assign last_idx_s  = 4'd15 - head_s[131:128];

    // Split the head entry into its 16 transmit bytes, byte 0 in the top bits.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            bytes_s[i] = head_s[127-8*i -: 8];
        end
    end

    // Next occupancy from simultaneous push/pop.
    always_comb begin
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CW'(1);
            2'b01:   count_n_s = count_r - CW'(1);
            default: count_n_s = count_r;
        endcase
    end

    // Word storage; contents need no reset since the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= iv_pkt_data;
        end
    end

    // FIFO pointers, count and write-side strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            rd_req_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            last_rx_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_n_s;
            rd_req_r   <= (count_n_s <= CW'(FIFO_DEPTH - 2));
            rx_valid_r <= push_s;
            last_rx_r  <= push_s & iv_pkt_data[133];
            overflow_r <= overflow_r | (i_pkt_data_wr & full_s);
        end
    end

    // Serializer: decides the byte registered onto GMII this edge and the next state.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        txd_n_s   = 8'h00;
        tx_en_n_s = 1'b0;
        tx_er_n_s = 1'b0;
        pop_s     = 1'b0;
        case (state_r)
            IDLE_S: begin
                if (!empty_s && head_flag_s[0]) begin
                    state_n_s = PRE_S;
                    cnt_n_s   = 16'd1;
                    txd_n_s   = 8'h55;
                    tx_en_n_s = 1'b1;
                end else if (!empty_s) begin
                    pop_s = 1'b1;
                end else begin
                    state_n_s = IDLE_S;
                end
            end
            PRE_S: begin
                tx_en_n_s = 1'b1;
                if (cnt_r == 16'd7) begin
                    txd_n_s   = 8'hD5;
                    state_n_s = DATA_S;
                    cnt_n_s   = 16'd0;
                end else begin
                    txd_n_s = 8'h55;
                    cnt_n_s = cnt_r + 16'd1;
                end
            end
            DATA_S: begin
                tx_en_n_s = 1'b1;
                if (empty_s) begin
                    tx_er_n_s = 1'b1;
                    state_n_s = DROP_S;
                    cnt_n_s   = 16'd0;
                end else begin
                    txd_n_s = bytes_s[cnt_r[3:0]];
                    if (head_flag_s[1] && (cnt_r[3:0] == last_idx_s)) begin
                        pop_s     = 1'b1;
                        state_n_s = IFG_S;
                        cnt_n_s   = 16'd0;
                    end else if (cnt_r[3:0] == 4'd15) begin
                        pop_s   = 1'b1;
                        cnt_n_s = 16'd0;
                    end else begin
                        cnt_n_s = cnt_r + 16'd1;
                    end
                end
            end
            DROP_S: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (head_flag_s[1]) begin
                        state_n_s = IFG_S;
                        cnt_n_s   = 16'd0;
                    end else begin
                        state_n_s = DROP_S;
                    end
                end else begin
                    state_n_s = DROP_S;
                end
            end
            IFG_S: begin
                if (cnt_r >= IFG_LAST) begin
                    state_n_s = IDLE_S;
                    cnt_n_s   = 16'd0;
                end else begin
                    cnt_n_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_n_s = IDLE_S;
                cnt_n_s   = 16'd0;
            end
        endcase
    end

    // FSM state and registered GMII outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE_S;
            cnt_r   <= 16'd0;
            txd_r   <= 8'h00;
            tx_en_r <= 1'b0;
            tx_er_r <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            txd_r   <= txd_n_s;
            tx_en_r <= tx_en_n_s;
            tx_er_r <= tx_er_n_s;
        end
    end

`ifdef NET_TX_STAT_EN
    logic [15:0] pkt_cnt_r;
    logic [15:0] underrun_cnt_r;
    logic        pkt_done_s;
    logic        underrun_s;

    assign pkt_done_s = (state_r == DATA_S) && (state_n_s == IFG_S);
    assign underrun_s = (state_r == DATA_S) && (state_n_s == DROP_S);

    // Wrapping frame and underrun counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt_r      <= 16'd0;
            underrun_cnt_r <= 16'd0;
        end else begin
            if (pkt_done_s) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end
            if (underrun_s) begin
                underrun_cnt_r <= underrun_cnt_r + 16'd1;
            end
        end
    end

    assign ov_tx_pkt_cnt      = pkt_cnt_r;
    assign ov_tx_underrun_cnt = underrun_cnt_r;
`endif

    assign o_pkt_rd_req        = rd_req_r;
    assign o_pkt_rx_valid      = rx_valid_r;
    assign o_pkt_last_cycle_rx = last_rx_r;
    assign ov_gmii_txd         = txd_r;
    assign o_gmii_tx_en        = tx_en_r;
    assign o_gmii_tx_er        = tx_er_r;
    assign o_fifo_overflow     = overflow_r;

endmodule

// File: tb/tb_network_tx_gmii_serializer.sv
// Directed bench for network_tx_gmii_serializer: table of frames plus hand-written corner sequences.
module tb_network_tx_gmii_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [133:0] pkt_data = '0;
    logic         pkt_wr = 1'b0;
    logic         rd_req;
    logic         rx_valid;
    logic         last_rx;
    logic [7:0]   txd;
    logic         tx_en;
    logic         tx_er;
    logic         overflow;
`ifdef NET_TX_STAT_EN
    logic [15:0]  pkt_cnt;
    logic [15:0]  underrun_cnt;
`endif

    network_tx_gmii_serializer dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .iv_pkt_data         (pkt_data),
        .i_pkt_data_wr       (pkt_wr),
        .o_pkt_rd_req        (rd_req),
        .o_pkt_rx_valid      (rx_valid),
        .o_pkt_last_cycle_rx (last_rx),
        .ov_gmii_txd         (txd),
        .o_gmii_tx_en        (tx_en),
        .o_gmii_tx_er        (tx_er),
        .o_fifo_overflow     (overflow)
`ifdef NET_TX_STAT_EN
        ,
        .ov_tx_pkt_cnt       (pkt_cnt),
        .ov_tx_underrun_cnt  (underrun_cnt)
`endif
    );

    always #4 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // GMII monitor state, sampled on the falling edge.
    logic [8:0] cap [0:255];
    int cap_len = 0;
    int in_frame = 0;
    int frames_done = 0;
    int idle_run = 0;
    int gap_last = 0;
    int en_cycles = 0;
    int er_cnt = 0;
    int rxv_cnt = 0;
    int last_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt = rxv_cnt + 1;
        if (last_rx) last_cnt = last_cnt + 1;
        if (tx_en) begin
            en_cycles = en_cycles + 1;
            if (in_frame == 0) begin
                in_frame = 1;
                cap_len = 0;
                gap_last = idle_run;
            end
            if (cap_len < 256) begin
                cap[cap_len] = {tx_er, txd};
                cap_len = cap_len + 1;
            end
            if (tx_er) er_cnt = er_cnt + 1;
        end else begin
            if (in_frame != 0) begin
                in_frame = 0;
                frames_done = frames_done + 1;
                idle_run = 0;
            end
            idle_run = idle_run + 1;
        end
    end

    typedef struct {
        int         nwords;
        logic [3:0] inv;
        int         gap;
        logic [7:0] seed;
        int         exp_len;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] make_data(input logic [7:0] seed, input int widx);
        logic [127:0] d;
        d = '0;
        for (int j = 0; j < 16; j++) begin
            d[127-8*j -: 8] = 8'(seed + 8'(16 * widx + j));
        end
        return d;
    endfunction

    task automatic put_word(input logic [1:0] fl, input logic [3:0] inv, input logic [127:0] d);
        pkt_wr = 1'b1;
        pkt_data = {fl, inv, d};
        @(posedge clk);
        #1;
        pkt_wr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] seed, input int nwords, input logic [3:0] inv, input int gap);
        for (int w = 0; w < nwords; w++) begin
            logic [1:0] fl;
            fl = {w == nwords - 1, w == 0};
            put_word(fl, (w == nwords - 1) ? inv : 4'd0, make_data(seed, w));
            repeat (gap - 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic clear_mon();
        rxv_cnt = 0;
        last_cnt = 0;
        er_cnt = 0;
        en_cycles = 0;
        frames_done = 0;
    endtask

    task automatic wait_frames(input int n, input string nm);
        int k;
        k = 0;
        while (frames_done < n && k < 2000) begin
            @(negedge clk);
            k = k + 1;
        end
        chk({nm, "_done"}, frames_done, n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string nm, input logic [7:0] seed, input int exp_len, input int exp_er);
        int bad;
        chk({nm, "_len"}, cap_len, 8 + exp_len + exp_er);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (cap[i] !== {1'b0, 8'h55}) bad = bad + 1;
        end
        if (cap[7] !== {1'b0, 8'hD5}) bad = bad + 1;
        chk({nm, "_preamble_bad"}, bad, 0);
        bad = 0;
        for (int k = 0; k < exp_len; k++) begin
            if (cap[8+k] !== {1'b0, 8'(seed + 8'(k))}) bad = bad + 1;
        end
        chk({nm, "_data_bad"}, bad, 0);
        chk({nm, "_er_cycles"}, er_cnt, exp_er);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int en_before;
        vecs[0] = '{nwords: 1, inv: 4'd4,  gap: 1,  seed: 8'h10, exp_len: 12};
        vecs[1] = '{nwords: 4, inv: 4'd0,  gap: 10, seed: 8'h30, exp_len: 64};
        vecs[2] = '{nwords: 2, inv: 4'd15, gap: 1,  seed: 8'hC0, exp_len: 17};
        vecs[3] = '{nwords: 3, inv: 4'd7,  gap: 3,  seed: 8'hE5, exp_len: 41};

        // Power-on reset.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_txd", txd, 0);
        chk("rst_tx_er", tx_er, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_strobes", {rx_valid, last_rx, overflow}, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("rd_req_before_clk", rd_req, 0);
        @(posedge clk);
        #1;
        chk("rd_req_after_release", rd_req, 1);
        repeat (3) begin @(posedge clk); #1; end

        // Table of normal frames.
        for (int v = 0; v < 4; v++) begin
            clear_mon();
            send_frame(vecs[v].seed, vecs[v].nwords, vecs[v].inv, vecs[v].gap);
            wait_frames(1, $sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v), vecs[v].seed, vecs[v].exp_len, 0);
            chk($sformatf("vec%0d_rx_valid", v), rxv_cnt, vecs[v].nwords);
            chk($sformatf("vec%0d_last", v), last_cnt, 1);
        end

        // Back-to-back single-word frames: exactly IFG idle cycles between them.
        clear_mon();
        put_word(2'b11, 4'd4, make_data(8'h11, 0));
        put_word(2'b11, 4'd0, make_data(8'h21, 0));
        wait_frames(1, "a1");
        check_frame("a1", 8'h11, 12, 0);
        wait_frames(2, "a2");
        check_frame("a2", 8'h21, 16, 0);
        chk("a_ifg_gap", gap_last, 12);
        chk("a_last", last_cnt, 2);

        // Fill the FIFO, overflow on the fifth word, then resend the tail once room appears.
        clear_mon();
        chk("b_rd_req_idle", rd_req, 1);
        put_word(2'b01, 4'd0, make_data(8'h40, 0));
        put_word(2'b00, 4'd0, make_data(8'h40, 1));
        put_word(2'b00, 4'd0, make_data(8'h40, 2));
        chk("b_rd_req_at3", rd_req, 0);
        chk("b_no_overflow_yet", overflow, 0);
        put_word(2'b00, 4'd0, make_data(8'h40, 3));
        put_word(2'b10, 4'd0, make_data(8'h40, 4));
        chk("b_overflow", overflow, 1);
        k = 0;
        while (rd_req == 1'b0 && k < 200) begin
            @(posedge clk);
            #1;
            k = k + 1;
        end
        chk("b_rd_req_returns", rd_req, 1);
        put_word(2'b10, 4'd0, make_data(8'h40, 4));
        wait_frames(1, "b");
        check_frame("b", 8'h40, 80, 0);
        chk("b_rx_valid", rxv_cnt, 5);
        chk("b_overflow_sticky", overflow, 1);

        // Underrun: head word only, rest of the frame arrives late and is discarded.
        clear_mon();
        put_word(2'b01, 4'd0, make_data(8'h60, 0));
        wait_frames(1, "c");
        check_frame("c", 8'h60, 16, 1);
        chk("c_er_slot", cap[24], 9'h100);
        en_before = en_cycles;
        repeat (15) begin @(posedge clk); #1; end
        put_word(2'b00, 4'd0, make_data(8'h60, 1));
        put_word(2'b00, 4'd0, make_data(8'h60, 2));
        put_word(2'b10, 4'd0, make_data(8'h60, 3));
        repeat (30) begin @(posedge clk); #1; end
        chk("c_drop_quiet", en_cycles, en_before);
        chk("c_rx_valid", rxv_cnt, 4);
`ifdef NET_TX_STAT_EN
        chk("c_underrun_cnt", underrun_cnt, 1);
`endif
        clear_mon();
        put_word(2'b11, 4'd8, make_data(8'h70, 0));
        wait_frames(1, "c2");
        check_frame("c2", 8'h70, 8, 0);

        // Middle-flag word in IDLE is discarded silently.
        clear_mon();
        put_word(2'b00, 4'd0, make_data(8'h80, 0));
        repeat (20) begin @(posedge clk); #1; end
        chk("d_quiet", en_cycles, 0);
        chk("d_rx_valid", rxv_cnt, 1);
        chk("d_last", last_cnt, 0);
        put_word(2'b11, 4'd0, make_data(8'h90, 0));
        wait_frames(1, "d");
        check_frame("d", 8'h90, 16, 0);
`ifdef NET_TX_STAT_EN
        chk("d_pkt_cnt", pkt_cnt, 9);
`endif

        // Reset in the middle of a frame.
        clear_mon();
        put_word(2'b01, 4'd0, make_data(8'hA0, 0));
        put_word(2'b10, 4'd0, make_data(8'hA0, 1));
        k = 0;
        while (!(in_frame != 0 && cap_len >= 29) && k < 500) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("e_reached_byte20", (cap_len >= 29) ? 1 : 0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("e_tx_en_async", tx_en, 0);
        chk("e_txd_async", txd, 0);
        chk("e_rd_req_async", rd_req, 0);
        chk("e_flags_async", {tx_er, rx_valid, last_rx, overflow}, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("e_rd_req_after_release", rd_req, 1);
        repeat (3) begin @(posedge clk); #1; end
        clear_mon();
        put_word(2'b11, 4'd2, make_data(8'hB0, 0));
        wait_frames(1, "e");
        check_frame("e", 8'hB0, 14, 0);
`ifdef NET_TX_STAT_EN
        chk("e_pkt_cnt", pkt_cnt, 1);
        chk("e_underrun_cnt", underrun_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
